mem_write_buffer: RTL
=====================

// Module: mem_write_buffer
// PURPOSE
//  Posted-write buffer between the processor and DataMemory. Writes retire in 1 cycle into a
//  DEPTH-entry FIFO drained to memory in the background; reads forward from the buffer when fully
//  covered, otherwise go to memory. CPU and memory sides both use start_access/access_done.
// PARAMETERS
//  DMEM_ADDRESS_WIDTH  20  byte address width, both sides; bits [2:0] always 0
//  DEPTH               4   buffer entries, power of 2, >= 2
//  DATA_BYTES          8   bytes per word; data width = 8*DATA_BYTES
// PORTS
//  clk               in   1       clock
//  reset             in   1       asynchronous, active-high; clears buffer and FSM
//  cpu_address       in   AW      word-aligned byte address
//  cpu_data_in       in   8*DB    write data
//  cpu_bytemask      in   DB      byte enables (writes only)
//  cpu_write         in   1       1 = write, 0 = read
//  cpu_start_access  in   1       request; inputs held stable until cpu_access_done
//  cpu_access_done   out  1       1-cycle completion pulse
//  cpu_data_out      out  8*DB    read data, valid only while cpu_access_done=1
//  mem_address       out  AW      to DataMemory
//  mem_data_in       out  8*DB    to DataMemory
//  mem_bytemask      out  DB      to DataMemory
//  mem_write         out  1       to DataMemory
//  mem_start_access  out  1       held until mem_access_done
//  mem_access_done   in   1       from DataMemory
//  mem_data_out      in   8*DB    from DataMemory
//  buf_count         out  clog2(DEPTH)+1  occupied entries
//  buf_empty         out  1       buf_count==0 and no drain in flight
// BEHAVIOUR
//  Reset: buffer empty, FSM IDLE; cpu_access_done=0, mem_start_access=0, cpu_data_out=0,
//   mem_* address/data/mask/write=0, buf_count=0, buf_empty=1. Mid-op reset drops all buffered writes.
//  Entry = {valid, addr, data, mask}. Head entry being drained is "locked" (no merge into it).
//  Write, cpu_start_access=1, cpu_write=1:
//   - unlocked valid entry with same addr: merge masked bytes into it, no new slot; done next cycle.
//   - else if not full: push at tail; cpu_access_done pulses the following cycle (latency 1).
//   - full: stall (no done) until a drain completes; accepted the cycle after the freeing pop.
//  Read, cpu_start_access=1, cpu_write=0:
//   - OR of masks of matching entries == all ones: forward, youngest byte wins, latency 1.
//   - no matching entry: issue memory read ahead of pending drains (priority over next drain,
//     never preempts one in flight); cpu_data_out=mem_data_out, done the cycle after mem_access_done.
//   - partial match: stall until all matching entries drained, then issue memory read.
//  FSM (memory side): IDLE -> DRAIN (buffer non-empty, no eligible read) | READ (eligible read);
//   DRAIN -> IDLE on mem_access_done (pop head, unlock); READ -> RESP on mem_access_done;
//   RESP -> IDLE (cpu_access_done=1 for exactly one cycle). mem_* outputs registered, stable
//   while mem_start_access=1; mem_start_access drops the cycle after mem_access_done.
//  Simultaneous push and pop in one cycle: buf_count unchanged; pointers wrap modulo DEPTH.
//  Back-to-back CPU requests (start held through done) accepted with no idle cycle.
//  Assertion: cpu_start_access=1 with cpu_address[2:0]!=0 outside reset is an error.
// STRUCTURE
//  Package mem_pkg: wb_entry_t struct, WORD_BYTES, ALIGN_BITS, wb_state_e {IDLE,DRAIN,READ,RESP}.
//  Sub-module wb_store: entry array, head/tail pointers, merge/match logic and forward-data mux;
//  top holds CPU handshake and memory FSM.
// TESTING (bench wraps this block around DataMemory, MODEL_NUMBER = student ID)
//  1 Write 0x0 <- 64'hDEADBEEF00000000 mask FF -> done in 1 cycle, buf_count=1; after drain
//    buf_empty=1; read 0x0 returns DEADBEEF00000000.
//  2 Write 0x10 mask 0F data ..11223344, then mask F0 data AABBCCDD..; read 0x10 before drain
//    -> forwarded AABBCCDD11223344 in 1 cycle, one entry used (merge).
//  3 DEPTH+1 writes to 0x0,0x8,..: first DEPTH complete in 1 cycle, last stalls until first
//    mem_access_done; all DEPTH+1 values read back correctly.
//  4 Write 0x20 mask 01, then read 0x20 -> read stalls until that entry drains, returns memory
//    bytes 7..1 with written byte 0.
//  5 Buffer holds writes to 0x40,0x48; read 0x80 -> issued to memory before 0x48 drains.
//  6 Assert reset mid-drain with 3 entries -> outputs at reset values same cycle; reads of those
//    addresses return initial memory contents.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_pkg : shared types for the posted-write buffer (entry, FSM states)      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package mem_pkg;

    localparam int WB_ADDR_W  = 20;
    localparam int WORD_BYTES = 8;
    localparam int ALIGN_BITS = $clog2(WORD_BYTES);

    typedef struct packed {
        logic                    valid;
        logic [WB_ADDR_W-1:0]    addr;
        logic [8*WORD_BYTES-1:0] data;
        logic [WORD_BYTES-1:0]   mask;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } wb_state_e;

    function automatic logic [8*WORD_BYTES-1:0] merge_bytes(
        input logic [8*WORD_BYTES-1:0] old_w,
        input logic [8*WORD_BYTES-1:0] new_w,
        input logic [WORD_BYTES-1:0]   mask
    );
        logic [8*WORD_BYTES-1:0] res;
        res = old_w;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_write_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_write_buffer_if : CPU-side and memory-side buses of the write buffer    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface mem_write_buffer_if #(
    parameter int AW = 20,
    parameter int DB = 8,
    parameter int CW = 3
);
    logic [AW-1:0]   cpu_address;
    logic [8*DB-1:0] cpu_data_in;
    logic [DB-1:0]   cpu_bytemask;
    logic            cpu_write;
    logic            cpu_start_access;
    logic            cpu_access_done;
    logic [8*DB-1:0] cpu_data_out;
    logic [AW-1:0]   mem_address;
    logic [8*DB-1:0] mem_data_in;
    logic [DB-1:0]   mem_bytemask;
    logic            mem_write;
    logic            mem_start_access;
    logic            mem_access_done;
    logic [8*DB-1:0] mem_data_out;
    logic [CW-1:0]   buf_count;
    logic            buf_empty;

    modport slave (
        input  cpu_address, cpu_data_in, cpu_bytemask, cpu_write, cpu_start_access,
        input  mem_access_done, mem_data_out,
        output cpu_access_done, cpu_data_out,
        output mem_address, mem_data_in, mem_bytemask, mem_write, mem_start_access,
        output buf_count, buf_empty
    );

    modport master (
        output cpu_address, cpu_data_in, cpu_bytemask, cpu_write, cpu_start_access,
        output mem_access_done, mem_data_out,
        input  cpu_access_done, cpu_data_out,
        input  mem_address, mem_data_in, mem_bytemask, mem_write, mem_start_access,
        input  buf_count, buf_empty
    );
endinterface
`default_nettype wire

// File: rtl/wb_store.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_store : circular entry array with merge lookup and byte-forwarding mux   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module wb_store
    import mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_ADDR_W,
    parameter int DB    = WORD_BYTES,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  wire              clk,
    input  wire              reset,
    input  wire [AW-1:0]     i_addr,
    input  wire [8*DB-1:0]   i_data,
    input  wire [DB-1:0]     i_mask,
    input  wire              i_lock_head,
    input  wire              i_merge,
    input  wire              i_push,
    input  wire              i_pop,
    output logic             o_merge_hit,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_rd_any,
    output logic [DB-1:0]    o_rd_mask,
    output logic [8*DB-1:0]  o_fwd_data,
    output logic [AW-1:0]    o_head_addr,
    output logic [8*DB-1:0]  o_head_data,
    output logic [DB-1:0]    o_head_mask,
    output logic [CW-1:0]    o_count
);
    localparam int PW = $clog2(DEPTH);

    wb_entry_t     r_ent [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [PW-1:0] w_merge_idx;
    logic [PW-1:0] w_idx;

    // The entry being drained is excluded so a late merge cannot miss memory.
    always_comb begin
        o_merge_hit = 1'b0;
        w_merge_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_ent[i].valid && (r_ent[i].addr == i_addr) &&
                !(i_lock_head && (PW'(i) == r_head))) begin
                o_merge_hit = 1'b1;
                w_merge_idx = PW'(i);
            end
        end
    end

    // Walk oldest to youngest so younger bytes overwrite older ones.
    always_comb begin
        o_rd_any   = 1'b0;
        o_rd_mask  = '0;
        o_fwd_data = '0;
        w_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (r_ent[w_idx].valid && (r_ent[w_idx].addr == i_addr)) begin
                o_rd_any   = 1'b1;
                o_rd_mask  = o_rd_mask | r_ent[w_idx].mask;
                o_fwd_data = merge_bytes(o_fwd_data, r_ent[w_idx].data, r_ent[w_idx].mask);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_merge) begin
                r_ent[w_merge_idx].data <= merge_bytes(r_ent[w_merge_idx].data, i_data, i_mask);
                r_ent[w_merge_idx].mask <= r_ent[w_merge_idx].mask | i_mask;
            end
            if (i_push) begin
                r_ent[r_tail] <= '{valid: 1'b1, addr: i_addr, data: i_data, mask: i_mask};
                r_tail        <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_ent[r_head].valid <= 1'b0;
                r_head              <= r_head + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full      = (r_count == CW'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_head_addr = r_ent[r_head].addr;
    assign o_head_data = r_ent[r_head].data;
    assign o_head_mask = r_ent[r_head].mask;
    assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_write_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_write_buffer : posted-write buffer, CPU handshake and memory-side FSM   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mem_write_buffer
    import mem_pkg::*;
#(
    parameter int DMEM_ADDRESS_WIDTH = WB_ADDR_W,
    parameter int DEPTH              = 4,
    parameter int DATA_BYTES         = WORD_BYTES
) (
    input  wire               clk,
    input  wire               reset,
    mem_write_buffer_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    wb_state_e                     r_state;
    logic                          r_cpu_done;
    logic [8*DATA_BYTES-1:0]       r_cpu_data;
    logic [DMEM_ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [8*DATA_BYTES-1:0]       r_mem_data;
    logic [DATA_BYTES-1:0]         r_mem_mask;
    logic                          r_mem_write;
    logic                          r_mem_start;

    logic                          w_merge_hit, w_full, w_empty, w_rd_any;
    logic [DATA_BYTES-1:0]         w_rd_mask, w_head_mask;
    logic [8*DATA_BYTES-1:0]       w_fwd_data, w_head_data;
    logic [DMEM_ADDRESS_WIDTH-1:0] w_head_addr;
    logic [CW-1:0]                 w_count;
    logic w_req, w_wr_req, w_rd_req, w_merge, w_push, w_fwd;
    logic w_rd_issue, w_drain_go, w_pop, w_lock_head;

    // Inputs still belong to the finished request while done is high.
    assign w_req       = bus.cpu_start_access && !r_cpu_done &&
                         ((r_state == IDLE) || (r_state == DRAIN));
    assign w_wr_req    = w_req && bus.cpu_write;
    assign w_rd_req    = w_req && !bus.cpu_write;
    assign w_merge     = w_wr_req && w_merge_hit;
    assign w_push      = w_wr_req && !w_merge_hit && !w_full;
    assign w_fwd       = w_rd_req && (&w_rd_mask);
    assign w_rd_issue  = w_rd_req && !w_rd_any && (r_state == IDLE);
    assign w_drain_go  = (r_state == IDLE) && !w_empty && !w_rd_issue;
    assign w_pop       = (r_state == DRAIN) && bus.mem_access_done;
    assign w_lock_head = (r_state == DRAIN) || w_drain_go;

    wb_store #(
        .DEPTH (DEPTH),
        .AW    (DMEM_ADDRESS_WIDTH),
        .DB    (DATA_BYTES),
        .CW    (CW)
    ) u_store (
        .clk         (clk),
        .reset       (reset),
        .i_addr      (bus.cpu_address),
        .i_data      (bus.cpu_data_in),
        .i_mask      (bus.cpu_bytemask),
        .i_lock_head (w_lock_head),
        .i_merge     (w_merge),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .o_merge_hit (w_merge_hit),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_rd_any    (w_rd_any),
        .o_rd_mask   (w_rd_mask),
        .o_fwd_data  (w_fwd_data),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_head_mask (w_head_mask),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cpu_done  <= 1'b0;
            r_cpu_data  <= '0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_mask  <= '0;
            r_mem_write <= 1'b0;
            r_mem_start <= 1'b0;
        end else begin
            r_cpu_done <= w_merge || w_push || w_fwd;
            if (w_fwd) r_cpu_data <= w_fwd_data;
            case (r_state)
                IDLE: begin
                    if (w_rd_issue) begin
                        r_state     <= READ;
                        r_mem_addr  <= bus.cpu_address;
                        r_mem_data  <= '0;
                        r_mem_mask  <= '1;
                        r_mem_write <= 1'b0;
                        r_mem_start <= 1'b1;
                    end else if (w_drain_go) begin
                        r_state     <= DRAIN;
                        r_mem_addr  <= w_head_addr;
                        r_mem_data  <= w_head_data;
                        r_mem_mask  <= w_head_mask;
                        r_mem_write <= 1'b1;
                        r_mem_start <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.mem_access_done) begin
                        r_state     <= IDLE;
                        r_mem_start <= 1'b0;
                    end
                end
                READ: begin
                    if (bus.mem_access_done) begin
                        r_state     <= RESP;
                        r_mem_start <= 1'b0;
                        r_cpu_done  <= 1'b1;
                        r_cpu_data  <= bus.mem_data_out;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_access_done  = r_cpu_done;
    assign bus.cpu_data_out     = r_cpu_data;
    assign bus.mem_address      = r_mem_addr;
    assign bus.mem_data_in      = r_mem_data;
    assign bus.mem_bytemask     = r_mem_mask;
    assign bus.mem_write        = r_mem_write;
    assign bus.mem_start_access = r_mem_start;
    assign bus.buf_count        = w_count;
    assign bus.buf_empty        = w_empty && (r_state != DRAIN);

    a_cpu_aligned: assert property (@(posedge clk) disable iff (reset)
        bus.cpu_start_access |-> (bus.cpu_address[ALIGN_BITS-1:0] == '0));

endmodule
`default_nettype wire
